// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority voting,
// a runtime baud divisor, runtime parity and stop-bit selection, and a
// one-entry output holding register with a valid/ready handshake that also
// reports overrun and break conditions.
module uart_rx_param #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  DataTx,
   input  logic [DIV_WIDTH-1:0]  BaudDiv,
   input  logic [1:0]            ParityType,
   input  logic                  StopBits,
   output logic [DATA_WIDTH-1:0] Data,
   output logic                  DataValid,
   input  logic                  DataReady,
   output logic [3:0]            ErrorFlag
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam int MID   = OVERSAMPLE / 2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(MID);
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_STOP2
   } state_t;

   state_t                state_q, state_d;
   logic                  sync1_q, sync1_d;
   logic                  rx_s_q, rx_s_d;
   logic                  armed_q, armed_d;
   logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
   logic [DIV_WIDTH-1:0]  div_lim_q, div_lim_d;
   logic [CNT_W-1:0]      samp_cnt_q, samp_cnt_d;
   logic                  samp1_q, samp1_d;
   logic                  samp2_q, samp2_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic                  zero_q, zero_d;
   logic                  pe_q, pe_d;
   logic                  fe_q, fe_d;
   logic                  brk_q, brk_d;
   logic [1:0]            par_lat_q, par_lat_d;
   logic                  stop2_lat_q, stop2_lat_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic [3:0]            err_q, err_d;

   logic                  commit;
   logic [DIV_WIDTH-1:0]  div_eff;
   logic                  tick;
   logic                  bit_end;
   logic                  decide;
   logic                  maj;
   logic                  has_par;
   logic                  exp_par;

   assign div_eff = (BaudDiv == '0) ? DIV_WIDTH'(1) : BaudDiv;
   assign tick    = (state_q != S_IDLE) && (div_cnt_q == div_lim_q - DIV_WIDTH'(1));
   assign bit_end = tick && (samp_cnt_q == CNT_LAST);
   assign decide  = tick && (samp_cnt_q == CNT_DEC);
   // Third sample is the live line value at the decision tick.
   assign maj     = (samp1_q & samp2_q) | (samp1_q & rx_s_q) | (samp2_q & rx_s_q);
   assign has_par = (par_lat_q == 2'b01) || (par_lat_q == 2'b10);
   assign exp_par = (par_lat_q == 2'b01) ? ~(^shreg_q) : (^shreg_q);

   // Synchroniser, baud tick generator and per-bit sample counter.
   always_comb begin
      // NOTE: every _d gets a default first so no path through this block can infer a latch.
      sync1_d    = DataTx;
      rx_s_d     = sync1_q;
      div_cnt_d  = div_cnt_q;
      div_lim_d  = div_lim_q;
      samp_cnt_d = samp_cnt_q;
      samp1_d    = samp1_q;
      samp2_d    = samp2_q;
      if (state_q == S_IDLE) begin
         div_cnt_d  = '0;
         div_lim_d  = div_eff;
         samp_cnt_d = '0;
      end else if (tick) begin
         // A new divisor is only picked up at a wrap.
         div_cnt_d  = '0;
         div_lim_d  = div_eff;
         samp_cnt_d = (samp_cnt_q == CNT_LAST) ? '0 : samp_cnt_q + CNT_W'(1);
         if (samp_cnt_q == CNT_S1) samp1_d = rx_s_q;
         if (samp_cnt_q == CNT_S2) samp2_d = rx_s_q;
      end else begin
         div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end
   end

   // Frame FSM: start detection, bit decisions, parity/stop checks and commit.
   always_comb begin
      state_d     = state_q;
      armed_d     = (state_q == S_IDLE) ? rx_s_q : 1'b0;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      zero_d      = zero_q;
      pe_d        = pe_q;
      fe_d        = fe_q;
      brk_d       = brk_q;
      par_lat_d   = par_lat_q;
      stop2_lat_d = stop2_lat_q;
      commit      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Only a falling edge counts: the line must have been seen high in IDLE.
            if (armed_q && !rx_s_q) begin
               state_d     = S_START;
               armed_d     = 1'b0;
               bit_idx_d   = '0;
               zero_d      = 1'b1;
               pe_d        = 1'b0;
               fe_d        = 1'b0;
               brk_d       = 1'b0;
               par_lat_d   = ParityType;
               stop2_lat_d = StopBits;
            end
         end
         S_START: begin
            if (decide && maj)  state_d = S_IDLE;
            else if (bit_end)   state_d = S_DATA;
         end
         S_DATA: begin
            if (decide) begin
               shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
               if (maj) zero_d = 1'b0;
            end
            if (bit_end) begin
               if (bit_idx_q == IDX_LAST) state_d = has_par ? S_PARITY : S_STOP;
               else                       bit_idx_d = bit_idx_q + IDX_W'(1);
            end
         end
         S_PARITY: begin
            if (decide) begin
               if (maj != exp_par) pe_d = 1'b1;
               if (maj) zero_d = 1'b0;
            end
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (decide && !maj) begin
               fe_d = 1'b1;
               if (zero_q) brk_d = 1'b1;
            end
            if (!stop2_lat_q) begin
               if (decide) begin
                  commit  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (bit_end) begin
               state_d = S_STOP2;
            end
         end
         S_STOP2: begin
            if (decide) begin
               if (!maj) fe_d = 1'b1;
               commit  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Holding register: commit, consume and overrun handling.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      if (commit) begin
         if (!valid_q || DataReady) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            err_d   = {brk_d, 1'b0, fe_d, pe_d};
         end else begin
            err_d[2] = 1'b1;
         end
      end else if (valid_q && DataReady) begin
         valid_d = 1'b0;
         err_d   = '0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (Reset) begin
         state_q     <= S_IDLE;
         // NOTE: synchroniser resets to the idle line level so reset cannot fake a start edge.
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         armed_q     <= 1'b0;
         div_cnt_q   <= '0;
         div_lim_q   <= DIV_WIDTH'(1);
         samp_cnt_q  <= '0;
         samp1_q     <= 1'b1;
         samp2_q     <= 1'b1;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         zero_q      <= 1'b0;
         pe_q        <= 1'b0;
         fe_q        <= 1'b0;
         brk_q       <= 1'b0;
         par_lat_q   <= 2'b00;
         stop2_lat_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rx_s_q      <= rx_s_d;
         armed_q     <= armed_d;
         div_cnt_q   <= div_cnt_d;
         div_lim_q   <= div_lim_d;
         samp_cnt_q  <= samp_cnt_d;
         samp1_q     <= samp1_d;
         samp2_q     <= samp2_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         zero_q      <= zero_d;
         pe_q        <= pe_d;
         fe_q        <= fe_d;
         brk_q       <= brk_d;
         par_lat_q   <= par_lat_d;
         stop2_lat_q <= stop2_lat_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign Data      = data_q;
   assign DataValid = valid_q;
   assign ErrorFlag = err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: directed scenarios plus randomized frames,
// checked against a frame-level reference model (bit lists, parity by
// counting ones, error flags from the bits actually sent).
module tb_uart_rx_param;

   localparam int OS  = 16;
   localparam int MID = OS / 2;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        DataTx;
   logic [15:0] BaudDiv;
   logic [1:0]  ParityType;
   logic        StopBits;
   logic        DataReady;

   logic [7:0]  d8;
   logic        v8;
   logic [3:0]  e8;
   logic [8:0]  d9;
   logic        v9;
   logic [3:0]  e9;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rise8  = -1;
   int rise9  = -1;
   logic v8_prev = 1'b0;
   logic v9_prev = 1'b0;

   bit   frame_q[$];
   bit   last_pbit;
   int   s;
   logic [8:0] rd;
   logic [1:0] rp;
   bit   ts, pf, s1, s2;
   int   rb, rdiv;

   uart_rx_param #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .DIV_WIDTH(16)) dut8 (
      .Clock(Clock), .Reset(Reset), .DataTx(DataTx), .BaudDiv(BaudDiv),
      .ParityType(ParityType), .StopBits(StopBits), .Data(d8),
      .DataValid(v8), .DataReady(DataReady), .ErrorFlag(e8)
   );

   uart_rx_param #(.DATA_WIDTH(9), .OVERSAMPLE(OS), .DIV_WIDTH(16)) dut9 (
      .Clock(Clock), .Reset(Reset), .DataTx(DataTx), .BaudDiv(BaudDiv),
      .ParityType(ParityType), .StopBits(StopBits), .Data(d9),
      .DataValid(v9), .DataReady(DataReady), .ErrorFlag(e9)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   // Record the edge at which each DataValid rises.
   always @(negedge Clock) begin
      if (v8 && !v8_prev) rise8 = cyc;
      if (v9 && !v9_prev) rise9 = cyc;
      v8_prev = v8;
      v9_prev = v9;
   end

   initial begin
      #800000;
      $error("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Parity bit a correct transmitter sends.
   function automatic bit good_parity(input int width, input logic [8:0] data, input logic [1:0] ptype);
      int ones = 0;
      for (int i = 0; i < width; i++) ones += int'(data[i]);
      return (ptype == 2'd2) ? (ones % 2 == 1) : (ones % 2 == 0);
   endfunction

   // Expected ErrorFlag for a frame, from the bits that were placed on the line.
   function automatic logic [3:0] model_err(input int width, input logic [8:0] data, input logic [1:0] ptype,
                                            input bit pbit, input bit two_stop, input bit st1, input bit st2);
      int ones = 0;
      bit has_par, pe, fe, brk;
      for (int i = 0; i < width; i++) ones += int'(data[i]);
      has_par = (ptype == 2'd1) || (ptype == 2'd2);
      pe  = has_par && (pbit != good_parity(width, data, ptype));
      fe  = !st1 || (two_stop && !st2);
      brk = (ones == 0) && !(has_par && pbit) && !st1;
      return {brk, 1'b0, fe | brk, pe};
   endfunction

   task automatic build_frame(input int width, input logic [8:0] data, input logic [1:0] ptype,
                              input bit par_flip, input bit two_stop, input bit st1, input bit st2);
      frame_q.delete();
      frame_q.push_back(1'b0);
      for (int i = 0; i < width; i++) frame_q.push_back(data[i]);
      last_pbit = 1'b0;
      if (ptype == 2'd1 || ptype == 2'd2) begin
         last_pbit = good_parity(width, data, ptype) ^ par_flip;
         frame_q.push_back(last_pbit);
      end
      frame_q.push_back(st1);
      if (two_stop) frame_q.push_back(st2);
   endtask

   // Drive frame bits first..last, OS*div clocks each, optional 1-clock glitch.
   task automatic tx_frame(input int div, input int first, input int last, input int gbit, input int goff);
      for (int i = first; i <= last && i < int'(frame_q.size()); i++) begin
         for (int c = 0; c < OS * div; c++) begin
            DataTx = (i == gbit && c == goff) ? ~frame_q[i] : frame_q[i];
            @(posedge Clock); #1;
         end
      end
      if (last >= int'(frame_q.size()) - 1) DataTx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic wait_valid(input string tag, input bit is9, input int budget);
      int n = 0;
      while (((is9 ? v9 : v8) !== 1'b1) && n < budget) begin
         @(posedge Clock); #1;
         n++;
      end
      check(tag, 32'(is9 ? v9 : v8), 32'd1);
   endtask

   task automatic consume();
      DataReady = 1'b1;
      @(posedge Clock); #1;
      DataReady = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; DataTx = 1'b1; DataReady = 1'b0;
      BaudDiv = 16'd1; ParityType = 2'b00; StopBits = 1'b0;
      idle(3);
      check("reset_valid", 32'(v8), 32'd0);
      check("reset_data",  32'(d8), 32'd0);
      check("reset_err",   32'(e8), 32'd0);
      Reset = 1'b0;
      idle(5);

      // 1: basic frame, exact commit latency, handshake clear.
      build_frame(8, 9'h0A5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      s = cyc; rise8 = -1;
      tx_frame(1, 0, 99, -1, 0);
      idle(2);
      // 2 synchroniser + 1 start-detect clocks, then stop bit (index 9) decision at count MID+1, commit one clock later.
      check("t1_latency", 32'(rise8), 32'(s + 3 + (OS * 9 + MID + 2) * 1));
      check("t1_valid", 32'(v8), 32'd1);
      check("t1_data",  32'(d8), 32'h0A5);
      check("t1_err",   32'(e8), 32'd0);
      consume();
      check("t1_cleared", 32'(v8), 32'd0);

      // 2: even parity, good then bad parity bit.
      ParityType = 2'b10;
      build_frame(8, 9'h037, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      check("t2_pbit_one", 32'(last_pbit), 32'd1);
      tx_frame(1, 0, 99, -1, 0); idle(2);
      wait_valid("t2a_valid", 1'b0, 50);
      check("t2a_data", 32'(d8), 32'h037);
      check("t2a_err",  32'(e8), 32'(model_err(8, 9'h037, 2'b10, last_pbit, 1'b0, 1'b1, 1'b1)));
      consume();
      build_frame(8, 9'h037, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
      tx_frame(1, 0, 99, -1, 0); idle(2);
      wait_valid("t2b_valid", 1'b0, 50);
      check("t2b_data", 32'(d8), 32'h037);
      check("t2b_err",  32'(e8), 32'b0001);
      consume();

      // 3: two stop bits with the second low, then a 12-bit-time break.
      ParityType = 2'b00; StopBits = 1'b1;
      build_frame(8, 9'h05A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      tx_frame(1, 0, 99, -1, 0); idle(2);
      wait_valid("t3a_valid", 1'b0, 50);
      check("t3a_data", 32'(d8), 32'h05A);
      check("t3a_err",  32'(e8), 32'b0010);
      consume();
      idle(20);
      frame_q.delete();
      repeat (12) frame_q.push_back(1'b0);
      tx_frame(1, 0, 99, -1, 0); idle(20);
      wait_valid("t3b_valid", 1'b0, 50);
      check("t3b_data", 32'(d8), 32'h000);
      check("t3b_err",  32'(e8), 32'(model_err(8, 9'h000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0)));
      check("t3b_err_lit", 32'(e8), 32'b1010);
      consume();
      idle(40);
      check("t3b_no_restart", 32'(v8), 32'd0);

      // 4: overrun with DataReady held low.
      StopBits = 1'b0;
      build_frame(8, 9'h011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      tx_frame(1, 0, 99, -1, 0);
      build_frame(8, 9'h022, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      tx_frame(1, 0, 99, -1, 0); idle(2);
      wait_valid("t4_valid", 1'b0, 50);
      check("t4_data", 32'(d8), 32'h011);
      check("t4_err",  32'(e8), 32'b0100);
      consume();
      check("t4_valid_drop", 32'(v8), 32'd0);
      check("t4_err_clear",  32'(e8), 32'd0);

      // 5: false start then a glitched frame.
      idle(10);
      rise8 = -1;
      DataTx = 1'b0; idle(4); DataTx = 1'b1;
      idle(60);
      check("t5_false_start", 32'(rise8), 32'hFFFF_FFFF);
      check("t5_no_valid",    32'(v8), 32'd0);
      build_frame(8, 9'h0C3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      tx_frame(1, 0, 99, 3, MID + 1); idle(2);
      wait_valid("t5_valid", 1'b0, 50);
      check("t5_data", 32'(d8), 32'h0C3);
      check("t5_err",  32'(e8), 32'd0);
      consume();
      idle(10);

      // Randomized frames with random divisor (0 behaves as 1), parity, stop bits and injected errors.
      for (int k = 0; k < 12; k++) begin
         rd = 9'($urandom_range(0, 255));
         rp = 2'($urandom_range(0, 3));
         ts = bit'($urandom_range(0, 1));
         pf = ($urandom_range(0, 3) == 0);
         s1 = ($urandom_range(0, 4) != 0);
         s2 = ($urandom_range(0, 4) != 0);
         rb = int'($urandom_range(0, 2));
         rdiv = (rb == 0) ? 1 : rb;
         BaudDiv = 16'(rb); ParityType = rp; StopBits = ts;
         build_frame(8, rd, rp, pf, ts, s1, s2);
         tx_frame(rdiv, 0, 99, -1, 0); idle(4);
         wait_valid($sformatf("rnd%0d_valid", k), 1'b0, 100);
         check($sformatf("rnd%0d_data", k), 32'(d8), 32'(rd[7:0]));
         check($sformatf("rnd%0d_err", k), 32'(e8), 32'(model_err(8, rd, rp, last_pbit, ts, s1, s2)));
         consume();
         idle(20);
      end

      // 6: 9-bit receiver, BaudDiv 3, odd parity, then reset mid-frame.
      Reset = 1'b1; idle(2); Reset = 1'b0; idle(5);
      BaudDiv = 16'd3; ParityType = 2'b01; StopBits = 1'b0;
      build_frame(9, 9'h1F0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
      s = cyc; rise9 = -1;
      tx_frame(3, 0, 99, -1, 0); idle(2);
      check("t6_latency", 32'(rise9), 32'(s + 3 + (OS * 11 + MID + 2) * 3));
      check("t6_data", 32'(d9), 32'h1F0);
      check("t6_err",  32'(e9), 32'(model_err(9, 9'h1F0, 2'b01, last_pbit, 1'b0, 1'b1, 1'b1)));
      build_frame(9, 9'h0A5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
      tx_frame(3, 0, 4, -1, 0);
      Reset = 1'b1; idle(1);
      check("t6_rst_valid", 32'(v9), 32'd0);
      check("t6_rst_data",  32'(d9), 32'd0);
      check("t6_rst_err",   32'(e9), 32'd0);
      check("t6_rst_v8",    32'(v8), 32'd0);
      tx_frame(3, 5, 99, -1, 0);
      idle(10); Reset = 1'b0; idle(10);
      check("t6_post_rst_idle", 32'(v9), 32'd0);
      build_frame(9, 9'h0A5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
      tx_frame(3, 0, 99, -1, 0); idle(2);
      wait_valid("t6b_valid", 1'b1, 100);
      check("t6b_data", 32'(d9), 32'h0A5);
      check("t6b_err",  32'(e9), 32'(model_err(9, 9'h0A5, 2'b01, last_pbit, 1'b0, 1'b1, 1'b1)));
      consume();
      check("t6b_cleared", 32'(v9), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
